// File: rtl/contadores_multicanal_if.sv
// Bus bundle for the multichannel event counter: push/idle/read request
// from the link side, snapshot read data and status back to it.
//
// Handshake: req is a single-cycle strobe with no backpressure. Every
// cycle with req=1 produces exactly one valid pulse on the following
// cycle. That pulse qualifies cuenta and err. A new req may be issued
// on every cycle.
interface contadores_multicanal_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 5,
  parameter int IDX_W  = 3
);
  logic [NUM_CH-1:0] push;
  logic              idle;
  logic              req;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cuenta;
  logic              valid;
  logic              err;
  logic [NUM_CH-1:0] ovf;
  logic [1:0]        estado;

  // Driver side: the link / host that pushes events and reads snapshots
  modport master (
    output push, idle, req, idx,
    input  cuenta, valid, err, ovf, estado
  );

  // Counter block side
  modport slave (
    input  push, idle, req, idx,
    output cuenta, valid, err, ovf, estado
  );
endinterface

// File: rtl/contadores_multicanal.sv
// Multichannel event counter with idle-window snapshot and readout.
// Live counters run in COUNT and SNAP. Entering SNAP (link idle) copies
// every live counter into a shadow bank. Reads are served from the shadow
// bank only while in SNAP, with one cycle of latency. estado exposes the
// FSM state directly.
module contadores_multicanal #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 5,
  parameter int IDX_W       = 3,
  parameter bit SATURATE    = 1'b0,
  parameter bit CLR_ON_SNAP = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  contadores_multicanal_if.slave bus
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_COUNT = 2'b01,
    ST_SNAP  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [CNT_W-1:0]  inc_val  [NUM_CH];
  logic [CNT_W-1:0]  shadow_q [NUM_CH];
  logic [CNT_W-1:0]  shadow_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;

  logic [CNT_W-1:0]  cuenta_q, cuenta_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic              count_en;
  logic              snap_edge;
  logic [CNT_W-1:0]  sel_val;
  logic              idx_ok;

  // Counting is held off for the single INIT cycle after reset release,
  // so the earliest increment lands on the second edge after release.
  assign count_en  = (state_q != ST_INIT);

  // The snapshot is taken on the edge that moves COUNT into SNAP.
  assign snap_edge = (state_q == ST_COUNT) && bus.idle;

  // Next-state logic: INIT -> COUNT unconditionally, COUNT <-> SNAP on idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:  state_d = ST_COUNT;
      ST_COUNT: if (bus.idle)  state_d = ST_SNAP;
      ST_SNAP:  if (!bus.idle) state_d = ST_COUNT;
      default:  state_d = ST_INIT;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-channel increment, overflow detection and snapshot capture.
  // inc_val is the counter value after this edge's push. The shadow
  // captures that value, so a push on the snapshot edge is included.
  // With clear-on-snap the live counter restarts from zero, so that
  // push is counted only once, in the shadow.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      inc_val[i] = cnt_q[i];
      if (count_en && bus.push[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i]   = 1'b1;
          inc_val[i] = SATURATE ? CNT_MAX : '0;
        end else begin
          inc_val[i] = cnt_q[i] + CNT_ONE;
        end
      end
      cnt_d[i]    = inc_val[i];
      shadow_d[i] = shadow_q[i];
      if (snap_edge) begin
        shadow_d[i] = inc_val[i];
        if (CLR_ON_SNAP) begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Live counters, shadow bank and sticky overflow flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
      ovf_q <= ovf_d;
    end
  end

  // Read decode. The mux is built as a compare loop, so an out-of-range
  // idx selects nothing and is reported through idx_ok. The read looks at
  // the pre-edge state, so a req on the edge where idle falls in SNAP is
  // still served. Shadows never change while in SNAP, so the value is
  // stable for the whole read window.
  always_comb begin
    sel_val = '0;
    idx_ok  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.idx == IDX_W'(i)) begin
        sel_val = shadow_q[i];
        idx_ok  = 1'b1;
      end
    end
    valid_d  = bus.req;
    err_d    = 1'b0;
    cuenta_d = cuenta_q;
    if (bus.req) begin
      if ((state_q == ST_SNAP) && idx_ok) begin
        cuenta_d = sel_val;
      end else begin
        err_d    = 1'b1;
        cuenta_d = '0;
      end
    end
  end

  // Read response registers. cuenta holds between reads. valid and err
  // are one-cycle pulses, and reset drops any response still pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cuenta_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cuenta_q <= cuenta_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  // All outputs come straight from registers, so push never reaches
  // an output through combinational logic.
  assign bus.cuenta = cuenta_q;
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;
  assign bus.ovf    = ovf_q;
  assign bus.estado = state_q;

endmodule

// File: tb/tb_contadores_multicanal.sv
// Bench for contadores_multicanal. Three instances (wrap, saturate,
// clear-on-snap) share the same clock, reset and stimulus. Each one is
// checked against a reference model that tracks plain event totals per
// channel.
module tb_contadores_multicanal;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 5;
  localparam int IDX_W  = 3;
  localparam int MAXV   = (1 << CNT_W) - 1;
  localparam int ND     = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  contadores_multicanal_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W)) if_a ();
  contadores_multicanal_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W)) if_s ();
  contadores_multicanal_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W)) if_c ();

  contadores_multicanal #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W),
    .SATURATE(1'b0), .CLR_ON_SNAP(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  contadores_multicanal #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W),
    .SATURATE(1'b1), .CLR_ON_SNAP(1'b0)) dut_s (.clk(clk), .reset(reset), .bus(if_s.slave));
  contadores_multicanal #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDX_W(IDX_W),
    .SATURATE(1'b0), .CLR_ON_SNAP(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(if_c.slave));

  // ---------------- counters ----------------
  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // m_tot holds the number of events seen since the last clear, without
  // any bound. The visible counter value is derived from it arithmetically.
  bit cfg_sat [ND] = '{1'b0, 1'b1, 1'b0};
  bit cfg_clr [ND] = '{1'b0, 1'b0, 1'b1};

  int m_state;                 // 0 INIT, 1 COUNT, 2 SNAP
  int m_tot    [ND][NUM_CH];
  int m_shadow [ND][NUM_CH];
  bit m_ovf    [ND][NUM_CH];
  int m_cuenta [ND];
  bit m_valid  [ND];
  bit m_err    [ND];

  function automatic int view(int d, int tot);
    if (cfg_sat[d]) return (tot > MAXV) ? MAXV : tot;
    return tot % (MAXV + 1);
  endfunction

  task automatic model_reset();
    m_state = 0;
    for (int d = 0; d < ND; d++) begin
      m_cuenta[d] = 0;
      m_valid[d]  = 1'b0;
      m_err[d]    = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_tot[d][i]    = 0;
        m_shadow[d][i] = 0;
        m_ovf[d][i]    = 1'b0;
      end
    end
  endtask

  // Predicts the effect of one rising edge with the given inputs applied.
  task automatic model_edge(input logic [NUM_CH-1:0] p, input logic id,
                            input logic rq, input logic [IDX_W-1:0] ix);
    for (int d = 0; d < ND; d++) begin
      m_valid[d] = rq;
      m_err[d]   = 1'b0;
      if (rq) begin
        if (m_state == 2 && int'(ix) < NUM_CH) begin
          m_cuenta[d] = m_shadow[d][int'(ix)];
        end else begin
          m_err[d]    = 1'b1;
          m_cuenta[d] = 0;
        end
      end
      if (m_state != 0) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (p[i]) m_tot[d][i]++;
          if (m_tot[d][i] > MAXV) m_ovf[d][i] = 1'b1;
        end
      end
      if (m_state == 1 && id) begin
        for (int i = 0; i < NUM_CH; i++) begin
          m_shadow[d][i] = view(d, m_tot[d][i]);
          if (cfg_clr[d]) m_tot[d][i] = 0;
        end
      end
    end
    case (m_state)
      0:       m_state = 1;
      1:       if (id)  m_state = 2;
      default: if (!id) m_state = 1;
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_one(input int d, input logic [CNT_W-1:0] cu, input logic v,
                           input logic e, input logic [NUM_CH-1:0] o, input logic [1:0] es);
    logic [NUM_CH-1:0] eo;
    for (int i = 0; i < NUM_CH; i++) eo[i] = m_ovf[d][i];
    chk($sformatf("dut%0d.cuenta", d), 32'(cu), 32'(m_cuenta[d]));
    chk($sformatf("dut%0d.valid", d),  32'(v),  32'(m_valid[d]));
    chk($sformatf("dut%0d.err", d),    32'(e),  32'(m_err[d]));
    chk($sformatf("dut%0d.ovf", d),    32'(o),  32'(eo));
    chk($sformatf("dut%0d.estado", d), 32'(es), 32'(m_state));
  endtask

  task automatic check_all();
    check_one(0, if_a.cuenta, if_a.valid, if_a.err, if_a.ovf, if_a.estado);
    check_one(1, if_s.cuenta, if_s.valid, if_s.err, if_s.ovf, if_s.estado);
    check_one(2, if_c.cuenta, if_c.valid, if_c.err, if_c.ovf, if_c.estado);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [NUM_CH-1:0] p, input logic id,
                       input logic rq, input logic [IDX_W-1:0] ix);
    if_a.push = p; if_a.idle = id; if_a.req = rq; if_a.idx = ix;
    if_s.push = p; if_s.idle = id; if_s.req = rq; if_s.idx = ix;
    if_c.push = p; if_c.idle = id; if_c.req = rq; if_c.idx = ix;
  endtask

  // Called at a falling edge: apply inputs, predict, then check at the next
  // falling edge, half a period after the rising edge that used them.
  task automatic step(input logic [NUM_CH-1:0] p, input logic id,
                      input logic rq, input logic [IDX_W-1:0] ix);
    drive(p, id, rq, ix);
    model_edge(p, id, rq, ix);
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_steps(input int n);
    logic id;
    id = 1'b0;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 7) == 0) id = ~id;
      step(NUM_CH'($urandom_range(0, (1 << NUM_CH) - 1)), id,
           1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, (1 << IDX_W) - 1)));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive('0, 1'b0, 1'b0, '0);
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();                                  // reset state
    reset = 1'b1;

    // Push in the INIT cycle must be ignored
    step(4'b1111, 1'b0, 1'b0, 3'd0);
    chk("init_estado", 32'(if_a.estado), 32'h1);

    // Count and read
    repeat (3) step(4'b0001, 1'b0, 1'b0, 3'd0);
    step(4'b0100, 1'b0, 1'b0, 3'd0);
    step(4'b0000, 1'b1, 1'b0, 3'd0);              // snapshot edge
    step(4'b0000, 1'b1, 1'b1, 3'd0);
    chk("read_ch0", 32'(if_a.cuenta), 32'd3);
    step(4'b0000, 1'b1, 1'b1, 3'd2);
    chk("read_ch2", 32'(if_a.cuenta), 32'd1);
    chk("read_ch2_err", 32'(if_a.err), 32'd0);
    step(4'b0000, 1'b1, 1'b0, 3'd0);
    chk("hold_cuenta", 32'(if_a.cuenta), 32'd1);

    // Error reads: in COUNT, then with an out-of-range idx in SNAP
    step(4'b0000, 1'b0, 1'b0, 3'd0);
    step(4'b0000, 1'b0, 1'b1, 3'd0);
    chk("err_count_state", {if_a.valid, if_a.err, 27'(if_a.cuenta)}, {1'b1, 1'b1, 27'd0});
    step(4'b0000, 1'b1, 1'b0, 3'd0);
    step(4'b0000, 1'b1, 1'b1, 3'd5);
    chk("err_bad_idx", {if_a.valid, if_a.err, 27'(if_a.cuenta)}, {1'b1, 1'b1, 27'd0});

    // idle falls on the same edge as a read in SNAP: still served
    step(4'b0000, 1'b0, 1'b1, 3'd0);
    chk("idle_fall_read", {if_a.valid, if_a.err, 27'(if_a.cuenta)}, {1'b1, 1'b0, 27'd3});

    // Wrap: 33 pushes on channel 1
    repeat (33) step(4'b0010, 1'b0, 1'b0, 3'd0);
    step(4'b0000, 1'b1, 1'b0, 3'd0);
    step(4'b0000, 1'b1, 1'b1, 3'd1);
    chk("wrap_read", 32'(if_a.cuenta), 32'd1);
    chk("wrap_ovf", 32'(if_a.ovf), 32'b0010);

    // Saturate: 40 pushes on channel 3
    step(4'b0000, 1'b0, 1'b0, 3'd0);
    repeat (40) step(4'b1000, 1'b0, 1'b0, 3'd0);
    step(4'b0000, 1'b1, 1'b0, 3'd0);
    step(4'b0000, 1'b1, 1'b1, 3'd3);
    chk("sat_read", 32'(if_s.cuenta), 32'd31);
    chk("sat_ovf3", 32'(if_s.ovf[3]), 32'd1);

    // Clear-on-snap: 4 pushes, a push on the snapshot edge, then 2 more
    step(4'b0000, 1'b0, 1'b0, 3'd0);
    repeat (4) step(4'b0001, 1'b0, 1'b0, 3'd0);
    step(4'b0001, 1'b1, 1'b0, 3'd0);
    step(4'b0000, 1'b1, 1'b1, 3'd0);
    chk("clr_read1", 32'(if_c.cuenta), 32'd5);
    step(4'b0000, 1'b0, 1'b0, 3'd0);
    repeat (2) step(4'b0001, 1'b0, 1'b0, 3'd0);
    step(4'b0000, 1'b1, 1'b0, 3'd0);
    step(4'b0000, 1'b1, 1'b1, 3'd0);
    chk("clr_read2", 32'(if_c.cuenta), 32'd2);

    // Randomized traffic
    rand_steps(400);

    // Async reset in the middle of a SNAP-state read
    step(4'b0000, 1'b1, 1'b0, 3'd0);
    step(4'b0000, 1'b1, 1'b0, 3'd0);
    chk("pre_reset_snap", 32'(if_a.estado), 32'h2);
    drive(4'b0000, 1'b1, 1'b1, 3'd0);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();                                  // cleared before the edge
    @(negedge clk);
    check_all();                                  // no valid pulse emerges
    drive(4'b0000, 1'b0, 1'b0, 3'd0);
    reset = 1'b1;
    step(4'b1111, 1'b0, 1'b0, 3'd0);              // INIT cycle ignores push
    rand_steps(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
